addsub_seq: RTL and testbench

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_seq_chunk_adder.sv | 29 ++
 rtl/addsub_seq.sv | 144 ++++++++++++++
 tb/tb_addsub_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the chunked sequential adder/subtractor.
// FSM state encoding and operation mode constants.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_seq_chunk_adder.sv
// CHUNK-bit ripple-carry adder, time-shared by addsub_seq.
// Also exposes the carry into the MSB for overflow detection.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = c_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Sequential adder/subtractor processing CHUNK bits per cycle.
// Operands are shifted down and the result shifted in from the top.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    import addsub_pkg::*;

    localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad
            $error("addsub_seq: CHUNK must divide WIDTH and be <= WIDTH");
        end
    endgenerate

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic cout_q, cout_d;
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;
    logic neg_q, neg_d;

    logic [CHUNK-1:0] add_s;
    logic add_co, add_cm;
    logic last;
    logic [WIDTH+CHUNK-1:0] sum_cat;

    chunk_adder #(.CHUNK(CHUNK)) u_add (
        .a_i    (xs_q[CHUNK-1:0]),
        .b_i    (ys_q[CHUNK-1:0]),
        .c_i    (carry_q),
        .sum_o  (add_s),
        .cout_o (add_co),
        .cmsb_o (add_cm)
    );

    assign last    = (cnt_q == CW'(N - 1));
    assign sum_cat = {add_s, sum_q};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        if (state_q == IDLE && in_valid) begin
            // Subtract is x + ~y + 1; the +1 rides in on the carry.
            cnt_d   = '0;
            xs_d    = x;
            ys_d    = (sub == MODE_SUB) ? ~y : y;
            carry_d = (sub == MODE_SUB) ? 1'b1 : c_in;
        end else if (state_q == RUN) begin
            cnt_d   = cnt_q + CW'(1);
            xs_d    = xs_q >> CHUNK;
            ys_d    = ys_q >> CHUNK;
            sum_d   = sum_cat[WIDTH+CHUNK-1:CHUNK];
            carry_d = add_co;
            if (last) begin
                cout_d = add_co;
                ovf_d  = add_co ^ add_cm;
                zero_d = (sum_d == '0);
                neg_d  = sum_d[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            xs_q    <= '0;
            ys_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign sum      = sum_q;
    assign c_out    = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign negative = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Randomized bench for addsub_seq against an arithmetic reference.
// Covers the 16/4 default build and an 8/8 single-chunk build.
module tb_addsub_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, c_in, sub;
    logic [15:0] x, y, sum;
    logic        out_valid, out_ready;
    logic        c_out, overflow, zero, negative;

    logic       v8, r8, ci8, sb8, ov8, or8;
    logic [7:0] x8, y8, s8;
    logic       co8, of8, z8, n8;

    int n_vec = 0;
    int n_bad = 0;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .overflow(overflow),
        .zero(zero), .negative(negative)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(v8), .in_ready(r8),
        .x(x8), .y(y8), .c_in(ci8), .sub(sb8),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8), .c_out(co8), .overflow(of8),
        .zero(z8), .negative(n8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: 17-bit arithmetic, overflow from operand/result signs.
    task automatic ref_op(input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s,
                          output logic [15:0] rs, output logic co,
                          output logic ov);
        logic [16:0] f;
        if (s) f = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else   f = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        rs = f[15:0];
        co = f[16];
        if (s) ov = (a[15] != b[15]) && (rs[15] != a[15]);
        else   ov = (a[15] == b[15]) && (rs[15] != a[15]);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic s, input int hold);
        logic [15:0] es;
        logic eco, eov;
        int lat;
        ref_op(a, b, ci, s, es, eco, eov);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; x = a; y = b; c_in = ci; sub = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom);
        c_in = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 50);
        check("latency", 32'(lat), 32'd4);
        check("sum", 32'(sum), 32'(es));
        check("c_out", 32'(c_out), 32'(eco));
        check("overflow", 32'(overflow), 32'(eov));
        check("zero", 32'(zero), 32'(es == 16'd0));
        check("negative", 32'(negative), 32'(es[15]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            x = 16'($urandom); y = 16'($urandom);
            @(posedge clk); #1;
            check("hold_sum", 32'(sum), 32'(es));
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_flags", 32'({c_out, overflow}), 32'({eco, eov}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ret_valid", 32'(out_valid), 32'd0);
        check("ret_ready", 32'(in_ready), 32'd1);
        check("ret_sum", 32'(sum), 32'(es));
    endtask

    initial begin
        int lat8;
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; c_in = 1'b0; sub = 1'b0;
        v8 = 1'b0; or8 = 1'b0; x8 = '0; y8 = '0; ci8 = 1'b0; sb8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", 32'({c_out, overflow, zero, negative}), 32'd0);

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 1);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0);
        run_op(16'h1234, 16'h1234, 1'b1, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 5);

        for (int i = 0; i < 40; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)));

        // Abort in the second RUN cycle.
        in_valid = 1'b1; x = 16'h1111; y = 16'h2222; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_quiet", 32'(out_valid), 32'd0);
        end
        run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 0);

        // Single-chunk build: latency 1.
        v8 = 1'b1; x8 = 8'h80; y8 = 8'h01; sb8 = 1'b1; ci8 = 1'b0;
        @(posedge clk); #1;
        v8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
        lat8 = 0;
        do begin
            @(posedge clk); #1;
            lat8++;
        end while (!ov8 && lat8 < 20);
        check("w8_latency", 32'(lat8), 32'd1);
        check("w8_sum", 32'(s8), 32'h7F);
        check("w8_c_out", 32'(co8), 32'd1);
        check("w8_overflow", 32'(of8), 32'd1);
        check("w8_negative", 32'(n8), 32'd0);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("w8_ret_ready", 32'(r8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
